// File: rtl/flatten_stage.sv
// flatten_stage: interleaves the two pooled channels (bank SEL_K0, bank SEL_K1)
// into the flattened bank SEL_OUT: K0[i] -> 2i, K1[i] -> 2i+1.
// Optional macro FLATTEN_CHECKSUM_EN adds a running unsigned sum of all
// written data on port cksum.
module flatten_stage #(
  parameter int unsigned N_ELEM  = 1024,
  parameter int unsigned DW      = 20,
  parameter logic [2:0]  SEL_K0  = 3'b011,
  parameter logic [2:0]  SEL_K1  = 3'b100,
  parameter logic [2:0]  SEL_OUT = 3'b101
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          crd,
  output logic [11:0]   caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [11:0]   caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
`ifdef FLATTEN_CHECKSUM_EN
  ,
  output logic [DW+10:0] cksum
`endif
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, FIN} state_t;

  localparam logic [10:0] IDX_LAST = 11'(N_ELEM - 1);

  state_t          state, state_nxt;
  logic [10:0]     idx;
  logic [DW-1:0]   d0, d1;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Element index, captured read data and busy/done flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx  <= '0;
      d0   <= '0;
      d1   <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          idx  <= '0;
          busy <= 1'b1;
        end
        RD0: d0 <= cdata_rd;
        RD1: d1 <= cdata_rd;
        WR1: begin
          if (idx == IDX_LAST) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            idx <= idx + 11'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and combinational memory-interface decode
  always_comb begin
    state_nxt = state;
    crd       = 1'b0;
    cwr       = 1'b0;
    csel      = 3'b000;
    caddr_rd  = '0;
    caddr_wr  = '0;
    cdata_wr  = '0;
    case (state)
      IDLE: if (start) state_nxt = RD0;
      RD0: begin
        crd       = 1'b1;
        csel      = SEL_K0;
        caddr_rd  = {1'b0, idx};
        state_nxt = RD1;
      end
      RD1: begin
        crd       = 1'b1;
        csel      = SEL_K1;
        caddr_rd  = {1'b0, idx};
        state_nxt = WR0;
      end
      WR0: begin
        cwr       = 1'b1;
        csel      = SEL_OUT;
        caddr_wr  = {idx, 1'b0};
        cdata_wr  = d0;
        state_nxt = WR1;
      end
      WR1: begin
        cwr       = 1'b1;
        csel      = SEL_OUT;
        caddr_wr  = {idx, 1'b1};
        cdata_wr  = d1;
        state_nxt = (idx == IDX_LAST) ? FIN : RD0;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FLATTEN_CHECKSUM_EN
  // Unsigned sum of every written word; cleared when a run is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      cksum <= '0;
    else if (state == IDLE && start) cksum <= '0;
    else if (cwr)                   cksum <= cksum + {11'd0, cdata_wr};
  end
`endif

endmodule

// File: tb/tb_flatten_stage.sv
// tb_flatten_stage: random/directed data in a behavioural layer memory,
// expected writes queued per run and compared by an independent monitor.
module tb_flatten_stage;
  localparam int N  = 1024;
  localparam int DW = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, crd, cwr;
  logic [11:0]   caddr_rd, caddr_wr;
  logic [DW-1:0] cdata_rd, cdata_wr;
  logic [2:0]    csel;
`ifdef FLATTEN_CHECKSUM_EN
  logic [DW+10:0] cksum;
`endif

  flatten_stage #(.N_ELEM(N), .DW(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
`ifdef FLATTEN_CHECKSUM_EN
    , .cksum(cksum)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] k0 [N];
  logic [DW-1:0] k1 [N];
  logic [DW-1:0] outm [4096];
  logic [31:0]   sb [$];   // {addr[11:0], data[19:0]}
  longint        exp_ck;
  int            errors = 0;
  int            checks = 0;

  // Behavioural memory: combinational read per bank, write on clock edge
  always_comb begin
    cdata_rd = '0;
    if (crd && caddr_rd < 12'(N)) begin
      if (csel == 3'b011)      cdata_rd = k0[caddr_rd[9:0]];
      else if (csel == 3'b100) cdata_rd = k1[caddr_rd[9:0]];
    end
  end

  always @(posedge clk) if (cwr) outm[caddr_wr] <= cdata_wr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: protocol rules every access cycle and scoreboard on each write
  always @(negedge clk) begin
    if (!reset && (crd || cwr)) begin
      chk("rd_wr_exclusive", {63'd0, crd && cwr}, 64'd0);
      if (crd) begin
        chk("csel_rd", {63'd0, csel == 3'b011 || csel == 3'b100}, 64'd1);
        chk("raddr_range", {63'd0, caddr_rd < 12'(N)}, 64'd1);
      end
      if (cwr) begin
        chk("csel_wr", {61'd0, csel}, 64'd5);
        chk("waddr_range", {63'd0, caddr_wr < 12'(2*N)}, 64'd1);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0h data %0h, none expected", caddr_wr, cdata_wr);
        end else begin
          logic [31:0] e;
          e = sb.pop_front();
          chk("wr_addr", {52'd0, caddr_wr}, {52'd0, e[31:20]});
          chk("wr_data", {44'd0, cdata_wr}, {44'd0, e[19:0]});
        end
      end
    end else if (!reset) begin
      chk("csel_idle", {61'd0, csel}, 64'd0);
    end
  end

  // Reference: the flattened image is K0/K1 interleaved element by element
  task automatic load_expect;
    sb.delete();
    exp_ck = 0;
    for (int i = 0; i < N; i++) begin
      sb.push_back({12'(2*i),   k0[i]});
      sb.push_back({12'(2*i+1), k1[i]});
      exp_ck += longint'(k0[i]) + longint'(k1[i]);
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One full run with stray start pulses mid-run; checks done timing and drain
  task automatic run_full;
    int   cyc;
    logic prev_busy;
    load_expect();
    pulse_start();
    cyc = 1;
    prev_busy = busy;
    while (!done && cyc < 5000) begin
      start = (cyc == 100 || cyc == 2001 || cyc == 4096);
      prev_busy = busy;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_cycle", 64'(cyc), 64'd4097);
    chk("busy_at_done", {63'd0, busy}, 64'd0);
    chk("busy_before_done", {63'd0, prev_busy}, 64'd1);
`ifdef FLATTEN_CHECKSUM_EN
    chk("cksum", {33'd0, cksum}, 64'(exp_ck));
`endif
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    // Reset held 3 cycles, then 10 idle cycles
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_outputs", {57'd0, busy, done, crd, cwr, csel}, 64'd0);
    end

    // Ramp data
    for (int i = 0; i < N; i++) begin
      k0[i] = 20'(i);
      k1[i] = 20'h80000 | 20'(i);
    end
    run_full();
    chk("ramp_out2", {44'd0, outm[2]}, 64'h1);
    chk("ramp_out2047", {44'd0, outm[2047]}, 64'h803FF);

    // Random data with extreme boundary values
    for (int i = 0; i < N; i++) begin
      k0[i] = 20'($urandom);
      k1[i] = 20'($urandom);
    end
    k0[0]   = 20'hFFFFF;
    k1[N-1] = 20'h00001;
    run_full();
    chk("bound_out0", {44'd0, outm[0]}, 64'hFFFFF);
    chk("bound_out2047", {44'd0, outm[2047]}, 64'h1);

    // Reset in the middle of a run
    for (int i = 0; i < N; i++) k0[i] = 20'($urandom);
    load_expect();
    pulse_start();
    repeat (1499) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset_outputs", {5'd0, busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr},
        64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("post_reset_idle", {62'd0, busy, cwr}, 64'd0);
    run_full();

`ifdef FLATTEN_CHECKSUM_EN
    for (int i = 0; i < N; i++) begin
      k0[i] = 20'h3;
      k1[i] = 20'h3;
    end
    run_full();
    chk("cksum_6144", {33'd0, cksum}, 64'd6144);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/flatten_stage.md
Name: flatten_stage

Overview:
- Downstream consumer of the conv/max-pool stage. Runs once the two 32x32 pooled channels (kernel 0 in bank csel=3'b011, kernel 1 in bank csel=3'b100) are complete in the shared layer memory.
- Reads both channels element by element and writes them interleaved into the flattened bank (csel=3'b101): K0[i] to address 2i, K1[i] to address 2i+1.
- Shares the single crd/cwr/csel memory interface with the conv stage. The top level grants the interface to this block only while busy=1.

Parameters:
- N_ELEM, 1024, elements per pooled channel (32x32); must be a power of two, at most 2048.
- DW, 20, data width of the layer memory.
- SEL_K0, 3'b011, bank select for the kernel-0 pooled map.
- SEL_K1, 3'b100, bank select for the kernel-1 pooled map.
- SEL_OUT, 3'b101, bank select for the flattened output.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: both pooled maps are ready.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the last write.
- crd  out  1  layer-memory read strobe.
- caddr_rd  out  12  read address.
- cdata_rd  in  DW  read data; combinational from memory, valid in the same cycle as crd/caddr_rd/csel.
- cwr  out  1  layer-memory write strobe.
- caddr_wr  out  12  write address.
- cdata_wr  out  DW  write data.
- csel  out  3  bank select; 3'b000 when idle.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, idx=0, busy=0, done=0. crd, cwr, caddr_rd, caddr_wr, cdata_wr and csel are all 0. Reset asserted mid-operation aborts immediately with no further writes. After reset deasserts, the block waits for a new start.
- FSM states: IDLE, RD0, RD1, WR0, WR1, FIN.
- IDLE: all strobes 0. start=1 -> RD0, busy<=1, idx<=0. start while busy is ignored.
- RD0: crd=1, csel=SEL_K0, caddr_rd=idx. d0<=cdata_rd at the closing edge. -> RD1.
- RD1: crd=1, csel=SEL_K1, caddr_rd=idx. d1<=cdata_rd. -> WR0.
- WR0: cwr=1, csel=SEL_OUT, caddr_wr={idx,1'b0}, cdata_wr=d0. -> WR1.
- WR1: cwr=1, csel=SEL_OUT, caddr_wr={idx,1'b1}, cdata_wr=d1.
  - idx==N_ELEM-1 -> FIN.
  - otherwise idx<=idx+1 -> RD0.
- FIN: done=1 for exactly one cycle, busy<=0 at the same edge. -> IDLE.
- crd and cwr are never high in the same cycle. csel is driven only while crd or cwr is high.
- The address and strobe outputs (crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr) are decoded combinationally from state and registers; they are 0 in non-matching states.
- Data passes through unmodified; no sign or ReLU processing, because the pooled data is already non-negative.
- Cycle budget: first RD0 occurs 1 cycle after start. Exactly 4*N_ELEM access cycles, then FIN. done appears 4*N_ELEM+1 cycles after the start cycle (4097 for the default).
- idx is 11 bits. The write address is 2*idx, which never exceeds 2047 for N_ELEM<=1024. No wrap-around is permitted; the bench checks that no address ever exceeds 2*N_ELEM-1.
- start in the same cycle as FIN is ignored; start must be re-issued once the block is back in IDLE.

Optional Feature:
- Macro FLATTEN_CHECKSUM_EN.
- Defined:
  - Adds output port cksum [DW+10:0].
  - Cleared to 0 on reset and when start is accepted.
  - Accumulates every cdata_wr value as an unsigned sum on each cwr cycle.
  - Holds its value from done until the next start.
- Undefined: the port and the accumulator are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: reset held 3 cycles, clocked 10 cycles without start -> busy=0, done=0, crd=cwr=0, csel=3'b000 throughout.
- Ramp: K0[i]=i, K1[i]=20'h80000|i, one start pulse -> out[2i]=i, out[2i+1]=20'h80000|i for all 1024 i; done rises exactly 4097 cycles after start; busy falls at that same edge.
- Boundary values: K0[0]=20'hFFFFF, K1[1023]=20'h00001 -> out[0]=20'hFFFFF, out[2047]=20'h00001; no write at address >= 2048.
- Protocol: every cycle while busy -> never crd&&cwr; csel equals SEL_K0 or SEL_K1 with crd, and SEL_OUT with cwr; start pulses mid-run have no effect on the sequence.
- Reset mid-run: assert reset at cycle 1500 after start -> all outputs 0 that cycle, no further cwr; a new start then completes a full correct flatten.
- FLATTEN_CHECKSUM_EN with every K0 and K1 element = 20'h00003 -> cksum=6144 (2048 writes x 3) after done.
